// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution: two line buffers feed a 3x3 window, then a two-stage MAC/clamp.
// Each output appears 2 clk after its trigger. in_ready drops only while flushing the last IMG_W+1 outputs.
module conv3x3_stream #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kernel1,
  input  logic       kernel2,
  input  logic       kernel3,
  input  logic       identity,
  input  logic [7:0] in_pix,
  input  logic       in_valid,
  input  logic       in_sof,
  output logic       in_ready,
  output logic [7:0] out_pix,
  output logic       out_valid,
  output logic       out_sof,
  output logic       out_eof
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int NW   = $clog2(NPIX + 1);
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);

  localparam logic [NW-1:0] N_FILL   = NW'(IMG_W);
  localparam logic [NW-1:0] N_LAST   = NW'(NPIX - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  localparam logic [1:0] K_ID    = 2'd0;
  localparam logic [1:0] K_SHARP = 2'd1;
  localparam logic [1:0] K_GAUSS = 2'd2;
  localparam logic [1:0] K_EDGE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          ready_q;
  logic [NW-1:0] n_q, n_d;
  logic [CW-1:0] icol_q, icol_d;
  logic [CW-1:0] ocol_q, ocol_d;
  logic [RW-1:0] orow_q, orow_d;
  logic [1:0]    kern_q, kern_d;

  logic          v0_q, sof0_q, eof0_q, bord0_q;
  logic [1:0]    kern0_q;
  logic          v1_q, sof1_q, eof1_q;
  logic signed [12:0] acc1_q;

  logic [7:0] lb0_q [IMG_W];
  logic [7:0] lb1_q [IMG_W];
  logic [7:0] win_q [3][3];

  logic          accept, sof_start, run_trig, flush_trig, trig, shift, out_last;
  logic [7:0]    pix_in;
  logic [CW-1:0] wr_col;
  logic [1:0]    sel;

  assign accept     = in_valid & ready_q;
  assign sof_start  = accept & in_sof;
  assign run_trig   = accept & ~in_sof & (state_q == S_RUN);
  assign flush_trig = (state_q == S_FLUSH);
  assign trig       = run_trig | flush_trig;
  assign shift      = sof_start | flush_trig |
                      (accept & ((state_q == S_FILL) | (state_q == S_RUN)));
  // Missing rows below the frame enter the window as zeros during flush.
  assign pix_in     = flush_trig ? 8'd0 : in_pix;
  assign wr_col     = sof_start ? '0 : icol_q;
  assign out_last   = (orow_q == ROW_LAST) & (ocol_q == COL_LAST);
  assign sel        = identity ? K_ID : kernel1 ? K_SHARP : kernel2 ? K_GAUSS :
                      kernel3 ? K_EDGE : K_ID;
  assign in_ready   = ready_q;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    icol_d  = icol_q;
    ocol_d  = ocol_q;
    orow_d  = orow_q;
    kern_d  = kern_q;
    if (sof_start) begin
      state_d = S_FILL;
      n_d     = NW'(1);
      icol_d  = CW'(1);
      ocol_d  = '0;
      orow_d  = '0;
      kern_d  = sel;
    end else begin
      if (shift)
        icol_d = (icol_q == COL_LAST) ? '0 : icol_q + CW'(1);
      if (accept && (state_q == S_FILL || state_q == S_RUN))
        n_d = n_q + NW'(1);
      if (accept && state_q == S_FILL && n_q == N_FILL)
        state_d = S_RUN;
      if (run_trig && n_q == N_LAST)
        state_d = S_FLUSH;
      if (trig) begin
        if (ocol_q == COL_LAST) begin
          ocol_d = '0;
          orow_d = orow_q + RW'(1);
        end else begin
          ocol_d = ocol_q + CW'(1);
        end
      end
      if (flush_trig && out_last)
        state_d = S_IDLE;
    end
  end

  // Window data and line buffers carry no reset; their contents are don't-care until refilled.
  always_ff @(posedge clk) begin
    if (shift) begin
      lb0_q[wr_col] <= pix_in;
      lb1_q[wr_col] <= lb0_q[wr_col];
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb1_q[wr_col];
      win_q[1][2] <= lb0_q[wr_col];
      win_q[2][2] <= pix_in;
    end
  end

  logic signed [12:0] px [3][3];
  logic signed [12:0] mac;
  logic [7:0]         clamp;

  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        px[r][c] = $signed({5'b0, win_q[r][c]});
    mac = '0;
    case (kern0_q)
      K_SHARP: mac = 13'sd5 * px[1][1] - px[0][1] - px[2][1] - px[1][0] - px[1][2];
      K_GAUSS: mac = (px[0][0] + px[0][2] + px[2][0] + px[2][2] +
                      13'sd2 * (px[0][1] + px[1][0] + px[1][2] + px[2][1]) +
                      13'sd4 * px[1][1]) >>> 4;
      K_EDGE:  mac = 13'sd8 * px[1][1] - (px[0][0] + px[0][1] + px[0][2] + px[1][0] +
                      px[1][2] + px[2][0] + px[2][1] + px[2][2]);
      default: mac = px[1][1];
    endcase
    if (bord0_q && kern0_q != K_ID)
      mac = '0;
  end

  assign clamp = acc1_q[12] ? 8'd0 : (acc1_q > 13'sd255) ? 8'd255 : acc1_q[7:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b0;
      n_q       <= '0;
      icol_q    <= '0;
      ocol_q    <= '0;
      orow_q    <= '0;
      kern_q    <= K_ID;
      v0_q      <= 1'b0;
      sof0_q    <= 1'b0;
      eof0_q    <= 1'b0;
      bord0_q   <= 1'b0;
      kern0_q   <= K_ID;
      v1_q      <= 1'b0;
      sof1_q    <= 1'b0;
      eof1_q    <= 1'b0;
      acc1_q    <= '0;
      out_pix   <= 8'd0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= (state_d != S_FLUSH);
      n_q       <= n_d;
      icol_q    <= icol_d;
      ocol_q    <= ocol_d;
      orow_q    <= orow_d;
      kern_q    <= kern_d;
      // Kernel travels with each output so in-flight pixels survive a restart.
      v0_q      <= trig;
      sof0_q    <= trig & (orow_q == '0) & (ocol_q == '0);
      eof0_q    <= trig & out_last;
      bord0_q   <= (orow_q == '0) | (orow_q == ROW_LAST) | (ocol_q == '0) | (ocol_q == COL_LAST);
      kern0_q   <= kern_q;
      v1_q      <= v0_q;
      sof1_q    <= sof0_q;
      eof1_q    <= eof0_q;
      acc1_q    <= mac;
      out_pix   <= v1_q ? clamp : 8'd0;
      out_valid <= v1_q;
      out_sof   <= sof1_q;
      out_eof   <= eof1_q;
    end
  end

endmodule

// File: doc/conv3x3_stream.md
Name: conv3x3_stream

Overview:
- Streaming 3x3 convolution stage; consumes the raster grayscale pixel stream read from image ROM.
- Produces the filtered pixel stream that the framebuffer writer stores for the VGA scan-out in main.
- Kernel is chosen by the board switches kernel1, kernel2, kernel3 and identity.
- Contains two line buffers, a 3x3 window, a kernel MAC/clamp pipeline and a frame sequencer.

Parameters:
IMG_W, 256, pixels per line (must be ≥3)
IMG_H, 256, lines per frame (must be ≥3)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
kernel1  input  1  select sharpen
kernel2  input  1  select gaussian blur
kernel3  input  1  select edge (Laplacian)
identity  input  1  select pass-through
in_pix  input  8  input pixel, unsigned gray
in_valid  input  1  in_pix valid
in_sof  input  1  marks first pixel of frame; qualified by in_valid
in_ready  output  1  block accepts in_pix this cycle
out_pix  output  8  filtered pixel
out_valid  output  1  out_pix valid; downstream always accepts
out_sof  output  1  with first output pixel of frame
out_eof  output  1  with last output pixel of frame

Behaviour:
- Reset (reset=0, async): all outputs 0, in_ready=0, counters 0, state IDLE. Line-buffer contents don't care.
- Accept = in_valid & in_ready.
- States:
  - IDLE: in_ready=1; accepting a pixel with in_sof=1 → FILL. Non-sof pixels are discarded.
  - FILL: accepts until IMG_W+1 pixels are in (incl. sof pixel) → RUN. No outputs.
  - RUN: each accept emits output for raster index n-(IMG_W+1), n = index of the accepted pixel. Accepting the last pixel (IMG_W*IMG_H-1) → FLUSH.
  - FLUSH: in_ready=0; emits the remaining IMG_W+1 outputs, one per cycle, using zero as data for missing rows. After the last output → IDLE.
- Latency: out_valid for output index k asserts exactly 2 clk after its trigger (the accept in RUN, or the FLUSH cycle). Outputs are strictly in raster order, exactly IMG_W*IMG_H per frame.
- in_valid gaps stall FILL/RUN without loss; out_valid pulses only on triggers.
- Kernel select:
  - Latched on the sof accept and held for the whole frame; mid-frame switch changes are ignored.
  - Priority: identity > kernel1 > kernel2 > kernel3; none asserted → identity.
- Kernels, applied to window w (centre c):
  - sharpen: 5c - N - S - E - W.
  - gaussian: (1 2 1 / 2 4 2 / 1 2 1) sum, then >>4 (truncate).
  - edge: 8c - sum of 8 neighbours.
  - identity: c.
- Arithmetic: signed 13-bit accumulator; result clamped to 0..255.
- Borders: row 0, row IMG_H-1, col 0 and col IMG_W-1 output 0 for all kernels except identity. Identity outputs c everywhere.
- Window never mixes lines across the column wrap; column/row counters derive border flags.
- out_sof: with output index 0. out_eof: with index IMG_W*IMG_H-1.
- in_sof while in FILL/RUN (mid-frame restart):
  - Current frame is abandoned with no further outputs and no out_eof.
  - Counters reset; that pixel starts a new frame (state FILL).
  - Pipeline outputs already in flight still emerge.
- in_sof is ignored while in FLUSH (in_ready=0).
- Reset mid-frame: immediate return to reset values.

Test Plan (IMG_W=4, IMG_H=4):
- Identity, constant 100 frame → 16 outputs all 100; out_sof on 1st, out_eof on 16th; first out_valid 2 clk after 6th accept.
- kernel2, constant 100 → interior (1,1),(1,2),(2,1),(2,2)=100; 12 border outputs=0.
- kernel3, constant 200 → all 16 outputs 0. kernel3, 255 at (1,1) else 0 → (1,1)=255, (2,2)=0 (clamped from -255).
- kernel1, 255 at (1,1) else 0 → (1,1)=255 (1275 clamped), (1,2)=0, (2,2)=0.
- Switch kernel1→kernel3 during pixel 8 → whole frame still sharpen. Random in_valid gaps → identical 16 outputs. in_ready=0 exactly 5 cycles in FLUSH.
- Drop reset during pixel 9 → outputs 0 immediately. New in_sof mid-frame → no out_eof for the old frame; the new frame completes with 16 correct outputs.
